// File: rtl/bcd_serial_adder_pkg.sv
// rtl/bcd_serial_adder_pkg.sv - shared state encoding and BCD constants for the serial BCD adder
package bcd_serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_DONE = DONE
  } state_t;

  localparam logic [4:0] BCD_MAX = 5'd9;
  localparam logic [4:0] BCD_ADJ = 5'd6;

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - combinational single-digit BCD add with decimal carry and bad-digit flag
module bcd_digit_cell
  import bcd_serial_adder_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       c_in,
  output logic [3:0] digit,
  output logic       c_out,
  output logic       bad
);

  logic [4:0] w_t;
  logic [4:0] w_adj;

  always_comb begin
    w_t   = {1'b0, a_d} + {1'b0, b_d} + {4'd0, c_in};
    w_adj = w_t + BCD_ADJ;
    c_out = (w_t > BCD_MAX);
    // Adding 6 may wrap past 5 bits for illegal digits; only the low nibble matters.
    digit = c_out ? w_adj[3:0] : w_t[3:0];
    bad   = ({1'b0, a_d} > BCD_MAX) | ({1'b0, b_d} > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - multi-digit packed-BCD adder, one digit pair per clock
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic            r_cout;
  logic            r_err;
  logic            r_out_valid;

  logic [3:0]      w_digit;
  logic            w_c_out;
  logic            w_bad;

  bcd_digit_cell u_cell (
    .a_d   (r_a[3:0]),
    .b_d   (r_b[3:0]),
    .c_in  (r_carry),
    .digit (w_digit),
    .c_out (w_c_out),
    .bad   (w_bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Operands shift right so the cell always sees the current digit in [3:0].
          r_a                 <= r_a >> 4;
          r_b                 <= r_b >> 4;
          r_sum[4*r_idx +: 4] <= w_digit;
          r_carry             <= w_c_out;
          r_err               <= r_err | w_bad;
          if (r_idx == LAST_IDX) begin
            r_cout      <= w_c_out;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign err       = r_err;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - directed and random checks of bcd_serial_adder with a result scoreboard
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        err;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } res_t;

  res_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mc);
    res_t r;
    int s = bcd2int(ma) + bcd2int(mb) + int'(mc);
    r.sum  = int2bcd(s % 10000);
    r.cout = (s >= 10000);
    r.err  = 1'b0;
    return r;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic push(input logic [15:0] s, input logic c, input logic e);
    res_t r;
    r.sum = s; r.cout = c; r.err = e;
    q.push_back(r);
  endtask

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input int hold);
    int   cyc;
    res_t e;
    @(negedge clk);
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    chk("in_ready_run", 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(DIGITS));
    chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sum", 32'(sum), 32'(e.sum));
      chk("cout", 32'(cout), 32'(e.cout));
      chk("err", 32'(err), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("hold_out_valid", 32'(out_valid), 32'd1);
        chk("hold_sum", 32'(sum), 32'(e.sum));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    res_t        m;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    push(16'h6912, 1'b0, 1'b0); run_op(16'h1234, 16'h5678, 1'b0, 0);
    push(16'h0000, 1'b1, 1'b0); run_op(16'h9999, 16'h0001, 1'b0, 0);
    push(16'h9999, 1'b1, 1'b0); run_op(16'h9999, 16'h9999, 1'b1, 0);
    push(16'h0001, 1'b0, 1'b0); run_op(16'h0000, 16'h0000, 1'b1, 5);
    push(16'h0100, 1'b0, 1'b1); run_op(16'h00A0, 16'h0000, 1'b0, 0);

    for (int k = 0; k < 6; k++) begin
      ra = rand_bcd(); rb = rand_bcd(); rc = 1'($urandom);
      m  = model(ra, rb, rc);
      q.push_back(m);
      run_op(ra, rb, rc, k % 2);
    end

    @(negedge clk);
    a = 16'h4321; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_rst_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    push(16'h0010, 1'b0, 1'b0); run_op(16'h0005, 16'h0005, 1'b0, 0);
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
